// File: rtl/psram_channel_arbiter_if.sv
// Bundle of requester A/B handshakes and the PSRAM IP user-side command/data bus.
// The arbiter uses the slave modport; the requester/PSRAM environment uses master.
interface psram_channel_arbiter_if;
  localparam int unsigned BA_W = 23;
  localparam int unsigned WA_W = 21;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = 8;
  localparam int unsigned MW   = 4;

  logic            init_calib;
  logic            ready;
  logic            a_req;
  logic            a_wr;
  logic [BA_W-1:0] a_address;
  logic [BW-1:0]   a_wdata;
  logic            a_ack;
  logic [BW-1:0]   a_rdata;
  logic            b_req;
  logic            b_wr;
  logic [BA_W-1:0] b_address;
  logic [BW-1:0]   b_wdata;
  logic            b_ack;
  logic [BW-1:0]   b_rdata;
  logic            cmd;
  logic            cmd_en;
  logic [WA_W-1:0] addr;
  logic [DW-1:0]   wr_data;
  logic [MW-1:0]   data_mask;
  logic [DW-1:0]   rd_data;
  logic            rd_data_valid;
  logic            timeout;

  modport slave (
    input  init_calib, a_req, a_wr, a_address, a_wdata,
           b_req, b_wr, b_address, b_wdata, rd_data, rd_data_valid,
    output ready, a_ack, a_rdata, b_ack, b_rdata,
           cmd, cmd_en, addr, wr_data, data_mask, timeout
  );

  modport master (
    output init_calib, a_req, a_wr, a_address, a_wdata,
           b_req, b_wr, b_address, b_wdata, rd_data, rd_data_valid,
    input  ready, a_ack, a_rdata, b_ack, b_rdata,
           cmd, cmd_en, addr, wr_data, data_mask, timeout
  );
endinterface

// File: rtl/psram_channel_arbiter.sv
// Round-robin sharing of one PSRAM channel between two byte requesters, issuing
// masked single-word commands with enforced cmd_en spacing and a read timeout.
module psram_channel_arbiter #(
  parameter int unsigned CMD_INTERVAL = 14,
  parameter int unsigned READ_TIMEOUT = 63
) (
  input logic                  clk,
  input logic                  rst_n,
  psram_channel_arbiter_if.slave bus
);
  localparam int unsigned BA_W = 23;
  localparam int unsigned WA_W = 21;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = 8;
  localparam int unsigned MW   = 4;
  localparam int unsigned CW   = 8;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_READ_WAIT, ST_GAP} state_t;

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic            cmd_q, cmd_d;
  logic            cmd_en_q, cmd_en_d;
  logic [WA_W-1:0] addr_q, addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [MW-1:0]   data_mask_q, data_mask_d;
  logic            a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [BW-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   gap_q, gap_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            last_b_q, last_b_d;
  logic            sel_b_q, sel_b_d;
  logic [1:0]      lane_q, lane_d;
  logic            valid_q;

  logic            grant_b;
  logic            req_wr;
  logic [BA_W-1:0] req_addr;
  logic [BW-1:0]   req_wdata;
  logic            rd_edge;
  logic [BW-1:0]   rd_byte;

  assign rd_edge = bus.rd_data_valid & ~valid_q;
  assign rd_byte = bus.rd_data[{lane_q, 3'b000} +: BW];

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    cmd_d       = cmd_q;
    cmd_en_d    = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    data_mask_d = data_mask_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    timeout_d   = 1'b0;
    gap_d       = (gap_q != '0) ? gap_q - CW'(1) : gap_q;
    wait_d      = wait_q;
    last_b_d    = last_b_q;
    sel_b_d     = sel_b_q;
    lane_d      = lane_q;
    grant_b     = 1'b0;
    req_wr      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;

    case (state_q)
      ST_INIT: begin
        if (bus.init_calib) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if ((gap_q == '0) && (bus.a_req || bus.b_req)) begin
          // On a tie the requester that did not win last time goes first
          grant_b   = bus.b_req & (~bus.a_req | ~last_b_q);
          req_wr    = grant_b ? bus.b_wr      : bus.a_wr;
          req_addr  = grant_b ? bus.b_address : bus.a_address;
          req_wdata = grant_b ? bus.b_wdata   : bus.a_wdata;
          last_b_d  = grant_b;
          sel_b_d   = grant_b;
          lane_d    = req_addr[1:0];
          cmd_en_d  = 1'b1;
          cmd_d     = req_wr;
          addr_d    = req_addr[BA_W-1:2];
          gap_d     = CW'(CMD_INTERVAL - 1);
          wait_d    = '0;
          if (req_wr) begin
            wr_data_d   = {4{req_wdata}};
            data_mask_d = ~(MW'(1) << req_addr[1:0]);
            a_ack_d     = ~grant_b;
            b_ack_d     = grant_b;
            state_d     = ST_GAP;
          end else begin
            data_mask_d = '0;
            state_d     = ST_READ_WAIT;
          end
        end
      end
      ST_READ_WAIT: begin
        wait_d = wait_q + CW'(1);
        if (rd_edge) begin
          a_rdata_d = sel_b_q ? a_rdata_q : rd_byte;
          b_rdata_d = sel_b_q ? rd_byte : b_rdata_q;
          a_ack_d   = ~sel_b_q;
          b_ack_d   = sel_b_q;
          state_d   = ST_GAP;
        end else if (wait_q == CW'(READ_TIMEOUT)) begin
          a_rdata_d = sel_b_q ? a_rdata_q : 8'hFF;
          b_rdata_d = sel_b_q ? 8'hFF : b_rdata_q;
          a_ack_d   = ~sel_b_q;
          b_ack_d   = sel_b_q;
          timeout_d = 1'b1;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and registered outputs; synchronous reset aborts any transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      ready_q     <= 1'b0;
      cmd_q       <= 1'b0;
      cmd_en_q    <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      data_mask_q <= 4'hF;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      timeout_q   <= 1'b0;
      gap_q       <= '0;
      wait_q      <= '0;
      last_b_q    <= 1'b1;
      sel_b_q     <= 1'b0;
      lane_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cmd_q       <= cmd_d;
      cmd_en_q    <= cmd_en_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      data_mask_q <= data_mask_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      timeout_q   <= timeout_d;
      gap_q       <= gap_d;
      wait_q      <= wait_d;
      last_b_q    <= last_b_d;
      sel_b_q     <= sel_b_d;
      lane_q      <= lane_d;
      valid_q     <= bus.rd_data_valid;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_en    = cmd_en_q;
  assign bus.addr      = addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.data_mask = data_mask_q;
  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_psram_channel_arbiter.sv
// Scoreboard bench for psram_channel_arbiter with a small PSRAM read-burst stub.
module tb_psram_channel_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psram_channel_arbiter_if bus();

  psram_channel_arbiter #(.CMD_INTERVAL(14), .READ_TIMEOUT(63)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit          is_b;
    bit          wr;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } cmd_exp_t;

  typedef struct {
    bit         is_b;
    bit         is_rd;
    logic [7:0] rdata;
    bit         tmo;
    int         lat;
  } ack_exp_t;

  localparam logic [78:0] RST_VEC = {1'b0, 1'b0, 1'b0, 21'h0, 32'h0, 4'hF,
                                     1'b0, 1'b0, 8'h00, 8'h00, 1'b0};

  cmd_exp_t cmd_q[$];
  ack_exp_t ack_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  last_cmd_cyc = -1000;
  bit  stub_en = 1'b1;
  bit  model_last_b = 1'b1;
  int  st_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // PSRAM stub: 4-beat burst starting a few cycles after a read command
  always @(posedge clk) begin
    if (!rst_n) begin
      st_cnt            <= 0;
      bus.rd_data_valid <= 1'b0;
      bus.rd_data       <= 32'hDEADBEEF;
    end else begin
      if (bus.cmd_en && !bus.cmd && stub_en) st_cnt <= 1;
      else if (st_cnt != 0) st_cnt <= (st_cnt >= 10) ? 0 : st_cnt + 1;
      case (st_cnt)
        5: begin bus.rd_data_valid <= 1'b1; bus.rd_data <= 32'h64656667; end
        6: begin bus.rd_data_valid <= 1'b1; bus.rd_data <= 32'h11223344; end
        7: begin bus.rd_data_valid <= 1'b1; bus.rd_data <= 32'h55667788; end
        8: begin bus.rd_data_valid <= 1'b1; bus.rd_data <= 32'h99AABBCC; end
        default: begin bus.rd_data_valid <= 1'b0; bus.rd_data <= 32'hDEADBEEF; end
      endcase
    end
  end

  function automatic logic [78:0] out_vec();
    return {bus.ready, bus.cmd, bus.cmd_en, bus.addr, bus.wr_data, bus.data_mask,
            bus.a_ack, bus.b_ack, bus.a_rdata, bus.b_rdata, bus.timeout};
  endfunction

  // Scoreboard monitor: pop expected command/ack entries as the DUT produces them
  cmd_exp_t   ce;
  ack_exp_t   ae;
  logic [59:0] c_obs, c_exp;
  logic [10:0] a_obs, a_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_cmd_cyc = -1000;
    end else begin
      if (bus.cmd_en) begin
        n_checks++;
        if (cyc - last_cmd_cyc < 14) begin
          n_fail++;
          $display("FAIL cmd_spacing: got %0d cycles, need >= 14", cyc - last_cmd_cyc);
        end
        last_cmd_cyc = cyc;
        n_checks++;
        if (cmd_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_cmd_en: got cmd=%0d addr=%h, expected none", bus.cmd, bus.addr);
        end else begin
          ce = cmd_q.pop_front();
          c_obs = {bus.cmd, bus.addr, bus.data_mask, ce.wr ? bus.wr_data : 32'h0, bus.a_ack, bus.b_ack};
          c_exp = {ce.wr, ce.addr, ce.mask, ce.wr ? ce.wdata : 32'h0,
                   ce.wr & ~ce.is_b, ce.wr & ce.is_b};
          if (c_obs !== c_exp) begin
            n_fail++;
            $display("FAIL cmd_fields: got %h expected %h (cmd,addr,mask,wr_data,a_ack,b_ack)", c_obs, c_exp);
          end
        end
      end
      if (bus.a_ack || bus.b_ack) begin
        n_checks++;
        if (ack_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: got a_ack=%0d b_ack=%0d, expected none", bus.a_ack, bus.b_ack);
        end else begin
          ae = ack_q.pop_front();
          a_obs = {bus.a_ack, bus.b_ack,
                   ae.is_rd ? (ae.is_b ? bus.b_rdata : bus.a_rdata) : 8'h00, bus.timeout};
          a_exp = {~ae.is_b, ae.is_b, ae.is_rd ? ae.rdata : 8'h00, ae.tmo};
          if (a_obs !== a_exp) begin
            n_fail++;
            $display("FAIL ack_fields: got %h expected %h (a_ack,b_ack,rdata,timeout)", a_obs, a_exp);
          end
          if (ae.lat != 0) begin
            n_checks++;
            if (cyc - last_cmd_cyc != ae.lat) begin
              n_fail++;
              $display("FAIL ack_latency: got %0d cycles, expected %0d", cyc - last_cmd_cyc, ae.lat);
            end
          end
        end
      end else if (bus.timeout) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout_without_ack: got timeout=1, expected an ack with it");
      end
    end
  end

  task automatic push_xact(input bit is_b, input bit wr, input logic [22:0] a,
                           input logic [7:0] d, input logic [7:0] rexp,
                           input bit tmo, input int lat);
    cmd_exp_t   c;
    ack_exp_t   k;
    logic [3:0] m;
    m       = 4'b0001 << a[1:0];
    c.is_b  = is_b;
    c.wr    = wr;
    c.addr  = a[22:2];
    c.wdata = {4{d}};
    c.mask  = wr ? ~m : 4'h0;
    k.is_b  = is_b;
    k.is_rd = !wr;
    k.rdata = rexp;
    k.tmo   = tmo;
    k.lat   = lat;
    cmd_q.push_back(c);
    ack_q.push_back(k);
  endtask

  // Raise a request and hold it until its ack (bounded), then drop it
  task automatic drive_req(input bit is_b, input bit wr, input logic [22:0] a,
                           input logic [7:0] d, input int bound);
    bit seen;
    seen = 1'b0;
    if (is_b) begin
      bus.b_wr = wr; bus.b_address = a; bus.b_wdata = d; bus.b_req = 1'b1;
    end else begin
      bus.a_wr = wr; bus.a_address = a; bus.a_wdata = d; bus.a_req = 1'b1;
    end
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      seen = is_b ? bus.b_ack : bus.a_ack;
    end
    if (is_b) bus.b_req = 1'b0;
    else      bus.a_req = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ack_wait: got no ack for %s addr %h within %0d cycles", is_b ? "B" : "A", a, bound);
    end
  endtask

  task automatic test_reset();
    int bad;
    bus.init_calib = 1'b0;
    bus.a_req = 1'b0; bus.a_wr = 1'b0; bus.a_address = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_wr = 1'b0; bus.b_address = '0; bus.b_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_vec() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", out_vec(), RST_VEC);
    end
    rst_n = 1'b1;
    push_xact(1'b0, 1'b1, 23'h000006, 8'h5A, 8'h00, 1'b0, 0);
    model_last_b = 1'b0;
    bus.a_wr = 1'b1; bus.a_address = 23'h000006; bus.a_wdata = 8'h5A; bus.a_req = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.cmd_en || bus.ready) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL init_hold: got %0d cycles with cmd_en/ready high, expected 0", bad);
    end
    bus.init_calib = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.ready, bus.cmd_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL ready_rise: got ready=%0d cmd_en=%0d expected ready=1 cmd_en=0", bus.ready, bus.cmd_en);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.cmd_en, bus.a_ack} !== 2'b11) begin
      n_fail++;
      $display("FAIL first_cmd: got cmd_en=%0d a_ack=%0d expected 1 1", bus.cmd_en, bus.a_ack);
    end
    bus.a_req = 1'b0;
  endtask

  task automatic test_write();
    push_xact(1'b1, 1'b1, 23'h7FFFFD, 8'hC3, 8'h00, 1'b0, 0);
    drive_req(1'b1, 1'b1, 23'h7FFFFD, 8'hC3, 100);
    push_xact(1'b0, 1'b1, 23'h000100, 8'h81, 8'h00, 1'b0, 0);
    drive_req(1'b0, 1'b1, 23'h000100, 8'h81, 100);
    push_xact(1'b1, 1'b1, 23'h2AAAAF, 8'h3C, 8'h00, 1'b0, 0);
    drive_req(1'b1, 1'b1, 23'h2AAAAF, 8'h3C, 100);
    model_last_b = 1'b1;
  endtask

  task automatic test_read();
    push_xact(1'b0, 1'b0, 23'h000004, 8'h00, 8'h67, 1'b0, 7);
    drive_req(1'b0, 1'b0, 23'h000004, 8'h00, 100);
    push_xact(1'b0, 1'b0, 23'h000007, 8'h00, 8'h64, 1'b0, 7);
    drive_req(1'b0, 1'b0, 23'h000007, 8'h00, 100);
    push_xact(1'b1, 1'b0, 23'h012345, 8'h00, 8'h66, 1'b0, 7);
    drive_req(1'b1, 1'b0, 23'h012345, 8'h00, 100);
    model_last_b = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit first_b;
    first_b = ~model_last_b;
    bus.init_calib = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (first_b) begin
        push_xact(1'b1, 1'b1, 23'h000200 + 23'(k), 8'hB0 + 8'(k), 8'h00, 1'b0, 0);
        push_xact(1'b0, 1'b1, 23'h000100 + 23'(k), 8'hA0 + 8'(k), 8'h00, 1'b0, 0);
      end else begin
        push_xact(1'b0, 1'b1, 23'h000100 + 23'(k), 8'hA0 + 8'(k), 8'h00, 1'b0, 0);
        push_xact(1'b1, 1'b1, 23'h000200 + 23'(k), 8'hB0 + 8'(k), 8'h00, 1'b0, 0);
      end
    end
    fork
      begin
        for (int k = 0; k < 3; k++)
          drive_req(1'b0, 1'b1, 23'h000100 + 23'(k), 8'hA0 + 8'(k), 200);
      end
      begin
        for (int k = 0; k < 3; k++)
          drive_req(1'b1, 1'b1, 23'h000200 + 23'(k), 8'hB0 + 8'(k), 200);
      end
    join
    model_last_b = ~first_b;
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_sticky: got ready=%0d after init_calib drop, expected 1", bus.ready);
    end
    bus.init_calib = 1'b1;
  endtask

  task automatic test_timeout();
    stub_en = 1'b0;
    push_xact(1'b1, 1'b0, 23'h000021, 8'h00, 8'hFF, 1'b1, 64);
    drive_req(1'b1, 1'b0, 23'h000021, 8'h00, 200);
    stub_en = 1'b1;
    push_xact(1'b1, 1'b0, 23'h00000A, 8'h00, 8'h65, 1'b0, 7);
    drive_req(1'b1, 1'b0, 23'h00000A, 8'h00, 100);
    model_last_b = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    cmd_exp_t c;
    bit seen;
    int acks;
    stub_en = 1'b0;
    c.is_b = 1'b0; c.wr = 1'b0; c.addr = 21'h000001; c.wdata = '0; c.mask = 4'h0;
    cmd_q.push_back(c);
    bus.a_wr = 1'b0; bus.a_address = 23'h000004; bus.a_wdata = '0; bus.a_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.cmd_en;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL abort_cmd_wait: got no cmd_en within 100 cycles");
    end
    repeat (3) @(negedge clk);
    bus.a_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_vec() !== RST_VEC) begin
      n_fail++;
      $display("FAIL mid_reset_values: got %h expected %h", out_vec(), RST_VEC);
    end
    rst_n = 1'b1;
    model_last_b = 1'b1;
    acks = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.a_ack || bus.b_ack || bus.timeout) acks++;
    end
    n_checks++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL abort_no_ack: got %0d ack/timeout cycles, expected 0", acks);
    end
    stub_en = 1'b1;
    push_xact(1'b0, 1'b0, 23'h000004, 8'h00, 8'h67, 1'b0, 7);
    drive_req(1'b0, 1'b0, 23'h000004, 8'h00, 100);
    model_last_b = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (cmd_q.size() != 0 || ack_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d cmd and %0d ack entries left, expected 0",
               cmd_q.size(), ack_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/psram_channel_arbiter.md
Name: psram_channel_arbiter

Overview:
Shares one PSRAM_Memory_Interface_2CH_Top channel between two byte-wide requesters (A, B), e.g. CPU slot and VDP/DMA.
- Round-robin arbitration between A and B.
- Converts byte accesses to single 32-bit word commands with data mask.
- Enforces the minimum spacing between cmd_en pulses.
- Returns the addressed byte of the first read beat.
- One instance per channel sits between the requester logic and the PSRAM IP.

Parameters:
CMD_INTERVAL, 14, minimum clk cycles from one cmd_en pulse to the next (range 2..255)
READ_TIMEOUT, 63, max clk cycles in ST_READ_WAIT before forced completion (range 1..255)

Ports:
clk  in  1  system clock; same clock as the PSRAM IP user side
rst_n  in  1  reset, synchronous, active-low
init_calib  in  1  PSRAM channel calibrated
ready  out  1  registered; 1 once init_calib is seen high, until reset
a_req  in  1  requester A access request, level, held until a_ack
a_wr  in  1  A: 1=write, 0=read
a_address  in  23  A byte address
a_wdata  in  8  A write byte
a_ack  out  1  A one-cycle completion pulse
a_rdata  out  8  A read byte, valid with a_ack, held until next A read completes
b_req, b_wr, b_address, b_wdata, b_ack, b_rdata  same as A, for requester B
cmd  out  1  to PSRAM: 1=write, 0=read
cmd_en  out  1  to PSRAM: one-cycle command strobe
addr  out  21  to PSRAM word address = latched address[22:2]
wr_data  out  32  to PSRAM: write byte replicated into all 4 lanes
data_mask  out  4  to PSRAM: 1 = lane not written
rd_data  in  32  from PSRAM
rd_data_valid  in  1  from PSRAM; high across the read burst beats
timeout  out  1  one-cycle pulse when a read is force-completed

Behaviour:
Reset state: ready=0, cmd=0, cmd_en=0, addr=0, wr_data=0, data_mask=4'hF, a_ack=b_ack=0, a_rdata=b_rdata=0, timeout=0, state=ST_INIT, gap counter=0, last_grant=B (so A wins the first tie).

All outputs are registered.

States:
- ST_INIT: wait for init_calib=1, then set ready=1 and go to ST_IDLE. Requests are ignored while in ST_INIT.
- ST_IDLE: act only if gap counter==0 and (a_req|b_req).
  - Grant rule: the single requester if only one is requesting; on a tie, the one not in last_grant. Update last_grant.
  - Latch wr, address, wdata of the winner.
  - Next cycle: cmd_en=1, cmd=wr, addr=address[22:2]. The gap counter loads CMD_INTERVAL-1 in the same cycle as cmd_en.
  - Write: wr_data={4{wdata}}; data_mask has all bits 1 except bit address[1:0]. Lane n is wr_data[8n+7:8n]. The winner's ack pulses in the same cycle as cmd_en. Go to ST_GAP.
  - Read: data_mask=4'h0. Go to ST_READ_WAIT.
- ST_READ_WAIT:
  - Capture on the rising edge of rd_data_valid (valid=1 and previous-cycle valid=0). Later beats of the burst are ignored.
  - Next cycle: winner's rdata = rd_data lane address[1:0], ack=1. Go to ST_GAP.
  - Timeout: if READ_TIMEOUT cycles pass after cmd_en with no edge, rdata=8'hFF, ack=1, timeout=1, go to ST_GAP.
- ST_GAP: go to ST_IDLE when gap counter==0. The gap counter decrements every cycle while nonzero, in any state.

Rules:
- cmd_en is never high two cycles in a row.
- cmd_en pulses are always at least CMD_INTERVAL cycles apart.
- Only one transaction is outstanding at a time.
- Non-granted requests stay pending and are not lost.
- Req still high in the cycle after ack = new request.
- Requester inputs are sampled only at grant; later changes to them are ignored.
- Reset mid-transaction aborts it: no ack is issued, and state returns to ST_INIT.
- init_calib dropping after ready=1 is ignored.

Test Plan:
1. Reset, hold init_calib=0 for 50 cycles with a_req=1 -> no cmd_en, ready=0. Raise init_calib -> ready=1 next cycle, then the first cmd_en follows.
2. A write a_address=23'h000006, a_wdata=8'h5A -> cmd_en=1, cmd=1, addr=21'h000001, wr_data=32'h5A5A5A5A, data_mask=4'b1011, a_ack in the same cycle.
3. A read a_address=23'h000004 against the stub (first beat 32'h64656667) -> a_rdata=8'h67. Repeat with address 23'h000007 -> 8'h64. Exactly one ack per read; burst beats 2-4 ignored.
4. a_req and b_req held high for 6 transactions -> grants alternate A,B,A,B,A,B. cmd_en spacing is always >=14. The stub never prints "[ERROR!!] BAD CMD_EN0".
5. Read with rd_data_valid tied low -> timeout pulse and b_ack with b_rdata=8'hFF, 64 cycles after cmd_en. The next request is serviced normally.
6. Assert rst_n=0 for 1 cycle while in ST_READ_WAIT -> all outputs return to reset values, no ack. Re-init then completes a read normally.
